cam_lookup_ctrl: RTL and testbench

- Sequencing controller in front of the 32-entry x 32-bit CAM.
- Turns single-beat client requests (LOOKUP, INSERT, DELETE, FLUSH) into CAM read/write/search cycles.
- Owns entry-valid bookkeeping and slot allocation; on a full CAM, evicts a round-robin victim.
- Sits between the client valid/ready port and the CAM ports; sole master of the CAM.

---
 rtl/cam_lookup_ctrl_pkg.sv | 34 +++
 rtl/cam_lookup_ctrl_if.sv | 60 ++++++
 rtl/cam_lookup_ctrl_free_finder.sv | 30 +++
 rtl/cam_lookup_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cam_lookup_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_lookup_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_ctrl_pkg
// Description : Shared constants, request opcodes and controller state
//               encoding for the CAM lookup controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_ctrl_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INDEX_WIDTH = 5;
  localparam int DEPTH       = 2 ** INDEX_WIDTH;

  // Client request opcodes.
  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_FLUSH  = 2'd3
  } op_t;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    SWAIT  = 3'd2,
    RDVIC  = 3'd3,
    RWAIT  = 3'd4,
    WRITE  = 3'd5,
    RESP   = 3'd6
  } state_t;

endpackage : cam_ctrl_pkg
`default_nettype wire

// File: rtl/cam_lookup_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cam_lookup_ctrl_if
// Description : Client request/response port plus CAM port of the lookup
//               controller. The slave modport is the controller's view; the
//               master modport is the surrounding client + CAM view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cam_lookup_ctrl_if;
  import cam_ctrl_pkg::*;

  // Client request / response
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [1:0]             req_op_i;
  logic [DATA_WIDTH-1:0]  req_data_i;
  logic [INDEX_WIDTH-1:0] req_index_i;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic                   rsp_hit_o;
  logic [INDEX_WIDTH-1:0] rsp_index_o;
  logic                   rsp_evict_o;
  logic [DATA_WIDTH-1:0]  rsp_evict_data_o;
  logic [INDEX_WIDTH:0]   occupancy_o;

  // CAM side
  logic                   cam_read_enable_o;
  logic [INDEX_WIDTH-1:0] cam_read_index_o;
  logic                   cam_write_enable_o;
  logic [INDEX_WIDTH-1:0] cam_write_index_o;
  logic [DATA_WIDTH-1:0]  cam_write_data_o;
  logic                   cam_search_enable_o;
  logic [DATA_WIDTH-1:0]  cam_search_data_o;
  logic                   cam_read_valid_i;
  logic [DATA_WIDTH-1:0]  cam_read_value_i;
  logic                   cam_search_valid_i;
  logic [INDEX_WIDTH-1:0] cam_search_index_i;

  modport slave (
    input  req_valid_i, req_op_i, req_data_i, req_index_i, rsp_ready_i,
           cam_read_valid_i, cam_read_value_i, cam_search_valid_i,
           cam_search_index_i,
    output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_evict_o,
           rsp_evict_data_o, occupancy_o, cam_read_enable_o, cam_read_index_o,
           cam_write_enable_o, cam_write_index_o, cam_write_data_o,
           cam_search_enable_o, cam_search_data_o
  );

  modport master (
    output req_valid_i, req_op_i, req_data_i, req_index_i, rsp_ready_i,
           cam_read_valid_i, cam_read_value_i, cam_search_valid_i,
           cam_search_index_i,
    input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_evict_o,
           rsp_evict_data_o, occupancy_o, cam_read_enable_o, cam_read_index_o,
           cam_write_enable_o, cam_write_index_o, cam_write_data_o,
           cam_search_enable_o, cam_search_data_o
  );

endinterface : cam_lookup_ctrl_if
`default_nettype wire

// File: rtl/cam_lookup_ctrl_free_finder.sv
`default_nettype none
// ============================================================================
// Module      : cam_free_finder
// Description : Lowest-zero priority encoder over the entry-valid bitmap.
//               Reports the lowest free entry and whether any entry is free.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_free_finder #(
  parameter int DEPTH       = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic [DEPTH-1:0]       i_valid,
  output logic [INDEX_WIDTH-1:0] o_free_index,
  output logic                   o_any_free
);

  // Scan from the top down so the lowest free entry is the last one written.
  always_comb begin
    o_free_index = '0;
    o_any_free   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        o_free_index = INDEX_WIDTH'(i);
        o_any_free   = 1'b1;
      end
    end
  end

endmodule : cam_free_finder
`default_nettype wire

// File: rtl/cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cam_lookup_ctrl
// Description : Sequencing controller in front of a 32 x 32-bit CAM. Turns
//               single-beat LOOKUP/INSERT/DELETE/FLUSH requests into CAM
//               search/read/write cycles, owns the entry-valid bitmap and
//               allocates slots, evicting round-robin when the CAM is full.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_lookup_ctrl
  import cam_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  cam_lookup_ctrl_if.slave ctrl
);

  localparam logic [INDEX_WIDTH:0]   C_OCC_ONE     = (INDEX_WIDTH + 1)'(1);
  localparam logic [INDEX_WIDTH-1:0] C_VICTIM_LAST = INDEX_WIDTH'(DEPTH - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  op_t                    r_op;
  logic [DATA_WIDTH-1:0]  r_key;
  logic [INDEX_WIDTH-1:0] r_widx;
  logic [INDEX_WIDTH-1:0] r_victim;
  logic [DEPTH-1:0]       r_valid;
  logic [INDEX_WIDTH:0]   r_occ;
  logic                   r_rsp_hit;
  logic [INDEX_WIDTH-1:0] r_rsp_index;
  logic                   r_rsp_evict;
  logic [DATA_WIDTH-1:0]  r_rsp_evict_data;

  op_t                    w_req_op;
  logic                   w_req_ready;
  logic                   w_accept;
  logic                   w_qhit;
  logic                   w_stale;
  logic                   w_any_free;
  logic [INDEX_WIDTH-1:0] w_free_index;

  assign w_req_op    = op_t'(ctrl.req_op_i);
  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign w_req_ready = (r_state == IDLE) && !rst_i;
  assign w_accept    = ctrl.req_valid_i && w_req_ready;
  // A CAM match only counts if the controller still considers the entry live;
  // a match on a dead entry is a stale key left behind by DELETE/FLUSH.
  assign w_qhit      = ctrl.cam_search_valid_i &&  r_valid[ctrl.cam_search_index_i];
  assign w_stale     = ctrl.cam_search_valid_i && !r_valid[ctrl.cam_search_index_i];

  cam_free_finder #(
    .DEPTH       (DEPTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_free_finder (
    .i_valid      (r_valid),
    .o_free_index (w_free_index),
    .o_any_free   (w_any_free)
  );

  // State register; reset aborts any in-flight operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_op == OP_LOOKUP || w_req_op == OP_INSERT) begin
            w_state_next = SEARCH;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      SEARCH: w_state_next = SWAIT;
      SWAIT: begin
        if (r_op == OP_LOOKUP || w_qhit) begin
          w_state_next = RESP;
        end else if (w_stale || w_any_free) begin
          w_state_next = WRITE;
        end else begin
          w_state_next = RDVIC;
        end
      end
      RDVIC: w_state_next = RWAIT;
      RWAIT: begin
        if (ctrl.cam_read_valid_i) begin
          w_state_next = WRITE;
        end
      end
      WRITE: w_state_next = RESP;
      RESP: begin
        if (ctrl.rsp_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture, bitmap/occupancy bookkeeping and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op             <= OP_LOOKUP;
      r_key            <= '0;
      r_widx           <= '0;
      r_victim         <= '0;
      r_valid          <= '0;
      r_occ            <= '0;
      r_rsp_hit        <= 1'b0;
      r_rsp_index      <= '0;
      r_rsp_evict      <= 1'b0;
      r_rsp_evict_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op             <= w_req_op;
            r_key            <= ctrl.req_data_i;
            r_rsp_hit        <= 1'b0;
            r_rsp_index      <= '0;
            r_rsp_evict      <= 1'b0;
            r_rsp_evict_data <= '0;
            if (w_req_op == OP_DELETE) begin
              r_valid[ctrl.req_index_i] <= 1'b0;
              r_rsp_hit                 <= r_valid[ctrl.req_index_i];
              r_rsp_index               <= ctrl.req_index_i;
              if (r_valid[ctrl.req_index_i]) begin
                r_occ <= r_occ - C_OCC_ONE;
              end
            end else if (w_req_op == OP_FLUSH) begin
              r_valid  <= '0;
              r_occ    <= '0;
              r_victim <= '0;
            end
          end
        end
        SWAIT: begin
          // Slot priority for an INSERT miss: stale match (keeps keys unique),
          // then lowest free entry, then the round-robin victim.
          if (r_op == OP_LOOKUP || w_qhit) begin
            r_rsp_hit   <= w_qhit;
            r_rsp_index <= w_qhit ? ctrl.cam_search_index_i : '0;
          end else if (w_stale) begin
            r_widx <= ctrl.cam_search_index_i;
          end else if (w_any_free) begin
            r_widx <= w_free_index;
          end else begin
            r_widx <= r_victim;
          end
        end
        RWAIT: begin
          if (ctrl.cam_read_valid_i) begin
            r_rsp_evict      <= 1'b1;
            r_rsp_evict_data <= ctrl.cam_read_value_i;
          end
        end
        WRITE: begin
          r_valid[r_widx] <= 1'b1;
          r_rsp_hit       <= 1'b0;
          r_rsp_index     <= r_widx;
          if (r_rsp_evict) begin
            r_victim <= (r_victim == C_VICTIM_LAST) ? '0 : r_victim + 1'b1;
          end else begin
            r_occ <= r_occ + C_OCC_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: strobes are pure functions of the state so reset kills them.
  always_comb begin
    ctrl.req_ready_o         = w_req_ready;
    ctrl.rsp_valid_o         = (r_state == RESP);
    ctrl.rsp_hit_o           = r_rsp_hit;
    ctrl.rsp_index_o         = r_rsp_index;
    ctrl.rsp_evict_o         = r_rsp_evict;
    ctrl.rsp_evict_data_o    = r_rsp_evict_data;
    ctrl.occupancy_o         = r_occ;
    ctrl.cam_search_enable_o = (r_state == SEARCH);
    ctrl.cam_search_data_o   = r_key;
    ctrl.cam_read_enable_o   = (r_state == RDVIC);
    ctrl.cam_read_index_o    = r_victim;
    ctrl.cam_write_enable_o  = (r_state == WRITE);
    ctrl.cam_write_index_o   = r_widx;
    ctrl.cam_write_data_o    = r_key;
  end

endmodule : cam_lookup_ctrl
`default_nettype wire

// File: tb/tb_cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_lookup_ctrl
// Description : Self-checking bench for cam_lookup_ctrl with a behavioural
//               CAM, a directed vector table, corner-case sequences and a
//               randomized phase against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_lookup_ctrl;
  import cam_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_lookup_ctrl_if bus ();

  cam_lookup_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .ctrl  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural CAM ----------------
  logic [31:0] cam_mem [DEPTH];
  logic [DEPTH-1:0] cam_written;
  int   wr_count = 0;
  int   last_rd_delay = 0;
  logic rd_pending;
  int   rd_wait;
  logic [4:0] rd_idx;
  int   rd_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cam_mem[i] <= '0;
      cam_written            <= '0;
      bus.cam_search_valid_i <= 1'b0;
      bus.cam_search_index_i <= '0;
      bus.cam_read_valid_i   <= 1'b0;
      bus.cam_read_value_i   <= '0;
      rd_pending             <= 1'b0;
      rd_wait                <= 0;
      rd_idx                 <= '0;
    end else begin
      if (bus.cam_write_enable_o) begin
        cam_mem[bus.cam_write_index_o]     <= bus.cam_write_data_o;
        cam_written[bus.cam_write_index_o] <= 1'b1;
        wr_count                           <= wr_count + 1;
      end
      bus.cam_search_valid_i <= 1'b0;
      bus.cam_search_index_i <= 5'($urandom);
      if (bus.cam_search_enable_o) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (cam_written[i] && cam_mem[i] == bus.cam_search_data_o) begin
            bus.cam_search_valid_i <= 1'b1;
            bus.cam_search_index_i <= 5'(i);
          end
        end
      end
      if (bus.cam_read_enable_o) begin
        rd_d = $urandom_range(0, 2);
        last_rd_delay = rd_d;
        if (rd_d == 0) begin
          bus.cam_read_valid_i <= 1'b1;
          bus.cam_read_value_i <= cam_mem[bus.cam_read_index_o];
        end else begin
          bus.cam_read_valid_i <= 1'b0;
          bus.cam_read_value_i <= $urandom;
          rd_pending           <= 1'b1;
          rd_wait              <= rd_d - 1;
          rd_idx               <= bus.cam_read_index_o;
        end
      end else if (rd_pending) begin
        if (rd_wait == 0) begin
          bus.cam_read_valid_i <= 1'b1;
          bus.cam_read_value_i <= cam_mem[rd_idx];
          rd_pending           <= 1'b0;
        end else begin
          bus.cam_read_valid_i <= 1'b0;
          bus.cam_read_value_i <= $urandom;
          rd_wait              <= rd_wait - 1;
        end
      end else begin
        bus.cam_read_valid_i <= 1'b0;
        bus.cam_read_value_i <= $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    op_t         op;
    logic [31:0] data;
    logic [4:0]  idx;
    logic        hit;
    logic [4:0]  rindex;
    logic        evict;
    logic [31:0] edata;
    int          occ;
    int          lat;
  } vec_t;

  bit          ref_valid   [DEPTH];
  bit          ref_written [DEPTH];
  logic [31:0] ref_key     [DEPTH];
  int          ref_occ;
  int          ref_victim;

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ref_valid[i] = 0; ref_written[i] = 0; ref_key[i] = '0;
    end
    ref_occ = 0; ref_victim = 0;
  endtask

  // Predicts the response from the behavioural rules (lat = cycles after the
  // accept edge; eviction latency excludes extra CAM read wait cycles).
  task automatic ref_step(input op_t op, input logic [31:0] data, input logic [4:0] idx,
                          output vec_t e);
    int m;
    int slot;
    e.op = op; e.data = data; e.idx = idx;
    e.hit = 0; e.rindex = '0; e.evict = 0; e.edata = '0; e.lat = 1;
    m = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (ref_written[i] && ref_key[i] == data) m = i;
    case (op)
      OP_LOOKUP: begin
        e.lat = 3;
        if (m >= 0 && ref_valid[m]) begin e.hit = 1; e.rindex = 5'(m); end
      end
      OP_INSERT: begin
        if (m >= 0 && ref_valid[m]) begin
          e.hit = 1; e.rindex = 5'(m); e.lat = 3;
        end else begin
          slot = 0;
          if (m >= 0) slot = m;
          else if (ref_occ < DEPTH) begin
            for (int i = DEPTH - 1; i >= 0; i--) if (!ref_valid[i]) slot = i;
          end else begin
            slot = ref_victim; e.evict = 1; e.edata = ref_key[slot];
            ref_victim = (ref_victim + 1) % DEPTH;
          end
          e.lat = e.evict ? 6 : 4;
          e.rindex = 5'(slot);
          ref_key[slot] = data; ref_written[slot] = 1;
          if (!ref_valid[slot]) begin ref_valid[slot] = 1; ref_occ++; end
        end
      end
      OP_DELETE: begin
        e.hit = ref_valid[idx];
        if (ref_valid[idx]) begin ref_valid[idx] = 0; ref_occ--; end
      end
      default: begin
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 0;
        ref_occ = 0; ref_victim = 0;
      end
    endcase
    e.occ = ref_occ;
  endtask

  // ---------------- driver ----------------
  logic        got_hit, got_evict;
  logic [4:0]  got_index;
  logic [31:0] got_edata;
  int          got_occ, got_lat, got_writes;

  task automatic do_req(input op_t op, input logic [31:0] data, input logic [4:0] idx,
                        input int hold);
    int g;
    int lat;
    int w0;
    @(negedge clk);
    g = 0;
    while (!bus.req_ready_o && g < 50) begin @(negedge clk); g++; end
    chk("req_ready before request", bus.req_ready_o, 1);
    w0 = wr_count;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_data_i  = data;
    bus.req_index_i = idx;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.rsp_valid_o && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("rsp_valid within bound", bus.rsp_valid_o, 1);
    got_hit = bus.rsp_hit_o; got_index = bus.rsp_index_o; got_evict = bus.rsp_evict_o;
    got_edata = bus.rsp_evict_data_o; got_occ = int'(bus.occupancy_o); got_lat = lat;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk("rsp held stable",
          {bus.rsp_valid_o, bus.rsp_hit_o, bus.rsp_index_o, bus.rsp_evict_o,
           bus.rsp_evict_data_o, bus.req_ready_o},
          {1'b1, got_hit, got_index, got_evict, got_edata, 1'b0});
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    chk("idle after handshake", {bus.rsp_valid_o, bus.req_ready_o}, 2'b01);
    got_writes = wr_count - w0;
  endtask

  task automatic check_rsp(input string tag, input vec_t e);
    chk({tag, " hit"}, got_hit, e.hit);
    if (e.op == OP_LOOKUP || e.op == OP_INSERT) chk({tag, " index"}, got_index, e.rindex);
    chk({tag, " evict"}, got_evict, e.evict);
    if (e.evict) chk({tag, " evict_data"}, got_edata, e.edata);
    chk({tag, " occupancy"}, got_occ, e.occ);
    chk({tag, " latency"}, got_lat, e.lat + (e.evict ? last_rd_delay : 0));
    if (e.op == OP_INSERT) chk({tag, " cam writes"}, got_writes, e.hit ? 0 : 1);
    else chk({tag, " cam writes"}, got_writes, 0);
  endtask

  function automatic vec_t mk(op_t op, logic [31:0] data, logic [4:0] idx, logic hit,
                              logic [4:0] rindex, logic evict, logic [31:0] edata,
                              int occ, int lat);
    vec_t v;
    v.op = op; v.data = data; v.idx = idx; v.hit = hit; v.rindex = rindex;
    v.evict = evict; v.edata = edata; v.occ = occ; v.lat = lat;
    return v;
  endfunction

  vec_t tab[$];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    vec_t dummy;
    int   g;
    op_t  rop;
    int   r;

    bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_data_i = '0;
    bus.req_index_i = '0;   bus.rsp_ready_i = 1'b0;
    ref_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", bus.req_ready_o, 0);
    chk("reset rsp_valid", bus.rsp_valid_o, 0);
    chk("reset occupancy", bus.occupancy_o, 0);
    chk("reset strobes", {bus.cam_read_enable_o, bus.cam_write_enable_o, bus.cam_search_enable_o}, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("req_ready after reset", bus.req_ready_o, 1);

    // Asynchronous reset in the middle of a WRITE.
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_op_i = OP_INSERT; bus.req_data_i = 32'hAAAA_0001;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    g = 0;
    while (!bus.cam_write_enable_o && g < 20) begin @(posedge clk); #1; g++; end
    chk("write strobe reached", bus.cam_write_enable_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("write strobe drops on async reset", bus.cam_write_enable_o, 0);
    chk("occupancy in mid-op reset", bus.occupancy_o, 0);
    chk("rsp_valid in mid-op reset", bus.rsp_valid_o, 0);
    @(negedge clk) rst = 1'b0;
    ref_reset();
    #1 chk("req_ready after mid-op reset", bus.req_ready_o, 1);

    // Directed vector table.
    tab.push_back(mk(OP_INSERT, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 4));
    tab.push_back(mk(OP_LOOKUP, 32'hDEADBEEF, 0, 1, 0, 0, 0, 1, 3));
    tab.push_back(mk(OP_INSERT, 32'hDEADBEEF, 0, 1, 0, 0, 0, 1, 3));
    tab.push_back(mk(OP_LOOKUP, 32'h12345678, 0, 0, 0, 0, 0, 1, 3));
    tab.push_back(mk(OP_FLUSH,  32'h0,        0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < DEPTH; i++)
      tab.push_back(mk(OP_INSERT, 32'h100 + i, 0, 0, 5'(i), 0, 0, i + 1, 4));
    tab.push_back(mk(OP_INSERT, 32'h200, 0, 0, 0, 1, 32'h100, 32, 6));
    tab.push_back(mk(OP_INSERT, 32'h201, 0, 0, 1, 1, 32'h101, 32, 6));
    tab.push_back(mk(OP_DELETE, 32'h0,   5, 1, 0, 0, 0, 31, 1));
    tab.push_back(mk(OP_DELETE, 32'h0,   5, 0, 0, 0, 0, 31, 1));
    tab.push_back(mk(OP_LOOKUP, 32'h105, 0, 0, 0, 0, 0, 31, 3));
    tab.push_back(mk(OP_INSERT, 32'h105, 0, 0, 5, 0, 0, 32, 4));
    tab.push_back(mk(OP_LOOKUP, 32'h105, 0, 1, 5, 0, 0, 32, 3));
    tab.push_back(mk(OP_INSERT, 32'h202, 0, 0, 2, 1, 32'h102, 32, 6));
    tab.push_back(mk(OP_LOOKUP, 32'h200, 0, 1, 0, 0, 0, 32, 3));
    tab.push_back(mk(OP_LOOKUP, 32'h11F, 0, 1, 31, 0, 0, 32, 3));
    foreach (tab[i]) begin
      ref_step(tab[i].op, tab[i].data, tab[i].idx, dummy);
      do_req(tab[i].op, tab[i].data, tab[i].idx, 0);
      check_rsp($sformatf("vec%0d", i), tab[i]);
    end

    // Response held off for 10 cycles.
    ref_step(OP_LOOKUP, 32'h201, 0, e);
    do_req(OP_LOOKUP, 32'h201, 0, 10);
    check_rsp("hold lookup", e);
    chk("hold lookup hit idx1", {got_hit, got_index}, {1'b1, 5'd1});

    // FLUSH, then keys still physically in the CAM must miss.
    ref_step(OP_FLUSH, 0, 0, e);
    do_req(OP_FLUSH, 0, 0, 0);
    check_rsp("flush", e);
    ref_step(OP_LOOKUP, 32'h201, 0, e);
    do_req(OP_LOOKUP, 32'h201, 0, 0);
    check_rsp("post-flush lookup 201", e);
    ref_step(OP_LOOKUP, 32'h110, 0, e);
    do_req(OP_LOOKUP, 32'h110, 0, 0);
    check_rsp("post-flush lookup 110", e);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      rop = OP_LOOKUP;
      else if (r < 80) rop = OP_INSERT;
      else if (r < 97) rop = OP_DELETE;
      else             rop = OP_FLUSH;
      e.data = ($urandom_range(0, 9) == 0) ? 32'h100 + $urandom_range(0, 31)
                                           : 32'h300 + $urandom_range(0, 47);
      e.idx = 5'($urandom);
      g = $urandom_range(0, 3);
      ref_step(rop, e.data, e.idx, e);
      do_req(rop, e.data, e.idx, g);
      check_rsp($sformatf("rnd%0d", n), e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cam_lookup_ctrl
`default_nettype wire
